// File: rtl/div_unit.sv
// Multi-cycle restoring divider: signed/unsigned, one quotient bit per cycle.
// Results register on leaving FIX and hold until the next completion or reset.
module div_unit #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam int CW = $clog2(SIZE + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] q_acc, r_acc, dvs_mag, dvd_lat;
    logic            neg_q, neg_r, dz;
    logic [SIZE:0]   r_shift;
    logic            fits, accept, last;
    logic            dvd_neg, dvs_neg;

    assign last    = (cnt == CW'(SIZE));
    assign r_shift = {r_acc, q_acc[SIZE-1]};
    assign fits    = (r_shift >= {1'b0, dvs_mag});
    assign dvd_neg = is_signed & dividend[SIZE-1];
    assign dvs_neg = is_signed & divisor[SIZE-1];
    assign busy    = (state == RUN) || (state == FIX);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start) begin accept = 1'b1; state_nxt = RUN; end
            RUN:  if (last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                if (start) begin accept = 1'b1; state_nxt = RUN; end
                else state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counter runs 0..SIZE: SIZE shift-subtract steps, then one settle cycle
    // in RUN before FIX, giving the SIZE+2 edge start-to-done latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            q_acc       <= '0;
            r_acc       <= '0;
            dvs_mag     <= '0;
            dvd_lat     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            q_acc   <= dvd_neg ? -dividend : dividend;
            r_acc   <= '0;
            dvs_mag <= dvs_neg ? -divisor : divisor;
            dvd_lat <= dividend;
            neg_q   <= dvd_neg ^ dvs_neg;
            neg_r   <= dvd_neg;
            dz      <= (divisor == '0);
        end else if (state == RUN && !last) begin
            cnt   <= cnt + 1'b1;
            q_acc <= {q_acc[SIZE-2:0], fits};
            r_acc <= fits ? SIZE'(r_shift - {1'b0, dvs_mag}) : r_shift[SIZE-1:0];
        end else if (state == FIX) begin
            // Overflow (-2^(SIZE-1) / -1) falls out naturally: magnitude 2^(SIZE-1), no negation.
            quotient    <= dz ? '1      : (neg_q ? -q_acc : q_acc);
            remainder   <= dz ? dvd_lat : (neg_r ? -r_acc : r_acc);
            div_by_zero <= dz;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, checked on done.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, is_signed;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        busy, done, div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    div_unit #(.SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dz = 1'b0;
        e.t0 = 0;
        if (b == 32'h0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'h0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Completion monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("latency", 64'(cyc - e.t0), 64'd34);
                chk("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; start is captured at the next posedge.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        if (push) begin
            e = model(s, a, b);
            e.t0 = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 64'(n), 64'd0);
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        issue(s, a, b, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int spur;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        // reset takes priority over simultaneous start
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        run_op(1'b0, 32'd100, 32'd7);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b0, 32'h1234_5678, 32'h0);
        run_op(1'b1, 32'h1234_5678, 32'h0);
        run_op(1'b1, 32'h8765_4321, 32'h0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op(1'b0, 32'd5, 32'd9);

        // start mid-RUN is ignored
        issue(1'b0, 32'd1000, 32'd33, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_run", 64'(busy), 64'd1);
        wait_done();
        // back-to-back: start in the DONE cycle
        issue(1'b1, 32'hFFFF_FC18, 32'd7, 1'b1);
        wait_done();
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom >> $urandom_range(0, 31);
            run_op(1'($urandom_range(0, 1)), a, b);
        end

        // reset mid-RUN aborts with no done pulse
        issue(1'b0, 32'd77, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q", 64'(quotient), 64'd0);
        chk("abort_r", 64'(remainder), 64'd0);
        chk("abort_dz", 64'(div_by_zero), 64'd0);
        spur = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) spur++;
        end
        chk("abort_no_done", 64'(spur), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a divide using the operands presented in the same cycle.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 = two's-complement divide (DIV), 0 = unsigned divide (DIVU); sampled with start.
REQ-006 SHALL have port dividend, input, SIZE bits: numerator; sampled with start.
REQ-007 SHALL have port divisor, input, SIZE bits: denominator; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse meaning the results are valid.
REQ-010 SHALL have port quotient, output, SIZE bits: result for LO.
REQ-011 SHALL have port remainder, output, SIZE bits: result for HI.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the last completed operation had divisor == 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, FIX and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on that edge it SHALL latch the operands, the sign flags and the operand magnitudes, clear the iteration counter, and go to RUN.
REQ-015 SHALL ignore start in RUN and FIX, with no effect on the operation in flight.
REQ-016 In RUN, SHALL perform one restoring shift-subtract step per cycle on the magnitudes: shift the partial remainder left taking the next dividend bit; if it is >= |divisor|, subtract and set the quotient bit, else set the quotient bit to 0.
REQ-017 After exactly SIZE RUN steps, SHALL go to FIX.
REQ-018 In FIX, SHALL negate the quotient when is_signed and the operand signs differ, and negate the remainder when is_signed and the dividend is negative; it SHALL then go to DONE.
REQ-019 In DONE, SHALL assert done for exactly one cycle, then go to IDLE unless start is accepted in that same cycle.
REQ-020 Latency: with start accepted at edge E, done SHALL be high in the cycle following edge E+SIZE+2 (SIZE+2 edges after E).
REQ-021 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-022 quotient, remainder and div_by_zero SHALL update only on the FIX-to-DONE transition and SHALL then hold until the next completion or reset.
REQ-023 Divisor == 0, signed or unsigned, SHALL take full latency and produce quotient = all ones, remainder = the latched dividend, div_by_zero = 1.
REQ-024 div_by_zero SHALL be 0 on every completion with a nonzero divisor.
REQ-025 Signed overflow (-2^(SIZE-1) / -1) SHALL produce quotient = -2^(SIZE-1) and remainder = 0, with div_by_zero = 0.
REQ-026 The sign rule SHALL be that signed results truncate toward zero and the remainder takes the sign of the dividend.
REQ-027 A start accepted in the DONE cycle SHALL begin a new operation with zero bubble; done SHALL still pulse for the finishing operation.

Reset
REQ-028 With rst_n low at a rising edge, SHALL go to IDLE and clear busy, done, quotient, remainder, div_by_zero and the counter to 0.
REQ-029 Reset in RUN or FIX SHALL abort the operation; no done pulse SHALL occur for it.
REQ-030 Reset SHALL take priority over a simultaneous start.

Verification
REQ-031 Unsigned, SIZE=32, dividend=100, divisor=7 -> done 34 edges after start; quotient=14, remainder=2, div_by_zero=0.
REQ-032 Signed, dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned with the same bits -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 Signed, dividend=0x80000000, divisor=0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-034 Divisor=0, dividend=0x12345678 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, with normal latency.
REQ-035 start pulsed mid-RUN with different operands -> ignored, the first result is returned unchanged; start in the DONE cycle -> the second result arrives 34 edges later.
REQ-036 rst_n low at RUN step 10 -> the next cycle has busy=0 and all outputs 0; no done pulse follows.
